multi_free_list: RTL

MULTI_FREE_LIST -- requirements
Module: multi_free_list

---
 rtl/multi_free_list.sv | 122 ++++++++++++
 1 files changed

// File: rtl/multi_free_list.sv
// Circular free list of physical registers: multi-lane allocate at head,
// multi-lane free at tail, and branch checkpoints that snapshot/restore head.
module multi_free_list #(
  parameter int PREG_WIDTH   = 6,
  parameter int NUM_AREGS    = 32,
  parameter int ALLOC_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int NUM_CKPT     = 4,
  localparam int CKPT_WIDTH  = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [ALLOC_WIDTH-1:0]             alloc_req,
  output logic                               alloc_grant,
  output logic [ALLOC_WIDTH*PREG_WIDTH-1:0]  alloc_preg,
  output logic [PREG_WIDTH:0]                free_count,
  input  logic [COMMIT_WIDTH-1:0]            commit_en,
  input  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] commit_old_preg,
  input  logic                               ckpt_save,
  output logic                               ckpt_ready,
  output logic [CKPT_WIDTH-1:0]              ckpt_id,
  input  logic                               resolve_en,
  input  logic [CKPT_WIDTH-1:0]              resolve_id,
  input  logic                               mispredict_en,
  input  logic [CKPT_WIDTH-1:0]              mispredict_id
);
  localparam int NUM_PREGS = 2 ** PREG_WIDTH;
  localparam int PTR_W     = PREG_WIDTH + 1;

  logic [PREG_WIDTH-1:0] queue [NUM_PREGS];
  logic [PTR_W-1:0]      head, tail, head_adv, head_nxt;
  logic [PTR_W-1:0]      alloc_cnt, commit_cnt, rd_ptr, wr_ptr;
  logic [PREG_WIDTH-1:0] wr_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] commit_ok;

  logic [NUM_CKPT-1:0] ckpt_valid, valid_nxt;
  logic [PTR_W-1:0]    ckpt_head [NUM_CKPT];
  logic [NUM_CKPT-1:0] ckpt_mask [NUM_CKPT];
  logic [NUM_CKPT-1:0] mask_nxt  [NUM_CKPT];
  logic                save_take, rs_hit, mp_hit;

  assign free_count = tail - head;

  // Requesting lanes read compacted slots; idle lanes peek at head+i.
  always_comb begin
    alloc_cnt  = '0;
    alloc_preg = '0;
    rd_ptr     = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      rd_ptr = head + (alloc_req[i] ? alloc_cnt : PTR_W'(i));
      alloc_preg[i*PREG_WIDTH +: PREG_WIDTH] = queue[rd_ptr[PREG_WIDTH-1:0]];
      alloc_cnt = alloc_cnt + PTR_W'(alloc_req[i]);
    end
  end

  assign alloc_grant = (alloc_cnt <= free_count);
  assign head_adv    = alloc_grant ? head + alloc_cnt : head;

  always_comb begin
    commit_cnt = '0;
    commit_ok  = '0;
    wr_ptr     = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      wr_ptr       = tail + commit_cnt;
      wr_idx[i]    = wr_ptr[PREG_WIDTH-1:0];
      commit_ok[i] = commit_en[i] && (commit_old_preg[i*PREG_WIDTH +: PREG_WIDTH] != '0);
      commit_cnt   = commit_cnt + PTR_W'(commit_ok[i]);
    end
  end

  always_comb begin
    ckpt_id = '0;
    for (int s = NUM_CKPT - 1; s >= 0; s--)
      if (!ckpt_valid[s]) ckpt_id = CKPT_WIDTH'(s);
  end

  assign ckpt_ready = ~&ckpt_valid;
  assign rs_hit     = resolve_en && ckpt_valid[resolve_id];
  assign mp_hit     = mispredict_en && ckpt_valid[mispredict_id];
  assign save_take  = ckpt_save && ckpt_ready && !mp_hit;
  assign head_nxt   = mp_hit ? ckpt_head[mispredict_id] : head_adv;

  // A mispredict kills the slot and every younger slot that recorded it as live.
  always_comb begin
    valid_nxt = ckpt_valid;
    mask_nxt  = ckpt_mask;
    if (save_take) begin
      valid_nxt[ckpt_id] = 1'b1;
      mask_nxt[ckpt_id]  = ckpt_valid;
    end
    if (rs_hit) begin
      valid_nxt[resolve_id] = 1'b0;
      for (int s = 0; s < NUM_CKPT; s++) mask_nxt[s][resolve_id] = 1'b0;
    end
    if (mp_hit) begin
      for (int s = 0; s < NUM_CKPT; s++)
        if (s == int'(mispredict_id) || ckpt_mask[s][mispredict_id]) valid_nxt[s] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head <= '0;
      tail <= PTR_W'(NUM_PREGS - NUM_AREGS);
      for (int i = 0; i < NUM_PREGS; i++)
        queue[i] <= (i < NUM_PREGS - NUM_AREGS) ? PREG_WIDTH'(i + NUM_AREGS) : '0;
      ckpt_valid <= '0;
      for (int s = 0; s < NUM_CKPT; s++) begin
        ckpt_head[s] <= '0;
        ckpt_mask[s] <= '0;
      end
    end else begin
      head <= head_nxt;
      tail <= tail + commit_cnt;
      for (int i = 0; i < COMMIT_WIDTH; i++)
        if (commit_ok[i]) queue[wr_idx[i]] <= commit_old_preg[i*PREG_WIDTH +: PREG_WIDTH];
      ckpt_valid <= valid_nxt;
      for (int s = 0; s < NUM_CKPT; s++) ckpt_mask[s] <= mask_nxt[s];
      if (save_take) ckpt_head[ckpt_id] <= head_adv;
    end
  end
endmodule
